cic_interp: RTL

Variable-rate cascaded integrator-comb interpolator for the transmit path; the upsampling counterpart of the receive-side CIC decimators. It requests low-rate baseband samples, runs the comb sections at the low rate and zero-stuffs them into integrator sections at the high (DAC-side) rate. It then rounds the result to the output width, with the scale set per interpolation rate. One instance per I/Q rail; it sits between the TX baseband source and the TX NCO/mixer.

---
 rtl/cic_interp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cic_interp.sv
// cic_interp: variable-rate CIC interpolator. The combs run at the low rate and the integrators run on zero-stuffed high-rate ticks.
// Optional macro CIC_INTERP_SAT_EN: clamp the rounded output instead of letting it wrap.
module cic_interp #(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int L2MI      = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           interpolation,
  input  logic                 rate_strobe,
  output logic                 in_strobe,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid
);
  localparam int ACC_WIDTH = IN_WIDTH + STAGES * L2MI;
  localparam int RB_WIDTH  = OUT_WIDTH + 1;

  function automatic logic [L2MI-1:0] supported_rate(input logic [7:0] r);
    case (r)
      8'd5, 8'd8, 8'd10, 8'd12, 8'd20, 8'd40: supported_rate = L2MI'(r);
      default:                                supported_rate = L2MI'(40);
    endcase
  endfunction

  // ceil(log2(R^(STAGES-1))) for the supported rates
  function automatic int growth(input logic [L2MI-1:0] r);
    case (r)
      L2MI'(5):  growth = 10;
      L2MI'(8):  growth = 12;
      L2MI'(10): growth = 14;
      L2MI'(12): growth = 15;
      L2MI'(20): growth = 18;
      default:   growth = 22;
    endcase
  endfunction

  logic [L2MI-1:0]             phase;
  logic [L2MI-1:0]             r_active;
  logic                        wrap;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] comb_data [STAGES];
  logic signed [ACC_WIDTH-1:0] last      [STAGES];
  logic signed [ACC_WIDTH-1:0] integ     [STAGES];
  logic                        stuff_pending;
  logic                        tick_d;
  int                          round_shift;
  logic [RB_WIDTH-1:0]         round_bits;
  logic [OUT_WIDTH-1:0]        rounded;
  logic [OUT_WIDTH-1:0]        result;

  assign wrap   = rate_strobe && (phase == r_active - L2MI'(1));
  assign in_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  // A new rate is picked up only at a period boundary, so phase never needs a reset on a rate change
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase     <= '0;
      in_strobe <= 1'b0;
      r_active  <= supported_rate(interpolation);
    end else begin
      in_strobe <= wrap;
      if (rate_strobe) phase <= wrap ? '0 : phase + L2MI'(1);
      if (wrap) r_active <= supported_rate(interpolation);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_data[k] <= '0;
        last[k]      <= '0;
      end
      stuff_pending <= 1'b0;
    end else if (in_strobe) begin
      comb_data[0] <= in_ext - last[0];
      last[0]      <= in_ext;
      for (int k = 1; k < STAGES; k++) begin
        comb_data[k] <= comb_data[k-1] - last[k];
        last[k]      <= comb_data[k-1];
      end
      stuff_pending <= 1'b1;
    end else if (rate_strobe) begin
      stuff_pending <= 1'b0;
    end
  end

  // Integrators wrap freely; the output slice is exact as long as the true result fits
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (rate_strobe) begin
      integ[0] <= integ[0] + (stuff_pending ? comb_data[STAGES-1] : '0);
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // round_bits holds the output slice plus the round bit just below it
  assign round_shift = IN_WIDTH - 1 + growth(r_active) - OUT_WIDTH;
  assign round_bits  = RB_WIDTH'(integ[STAGES-1] >>> round_shift);
  assign rounded     = round_bits[OUT_WIDTH:1] + OUT_WIDTH'(round_bits[0]);

`ifdef CIC_INTERP_SAT_EN
  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MAX = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] upper;

  assign upper = integ[STAGES-1] >>> (round_shift + OUT_WIDTH);

  always_comb begin
    result = rounded;
    if (!(upper == '0 || upper == '1))
      result = upper[ACC_WIDTH-1] ? NEG_MAX : POS_MAX;
    else if (round_bits[OUT_WIDTH:1] == POS_MAX && round_bits[0])
      result = POS_MAX;
  end
`else
  assign result = rounded;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_d    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      tick_d    <= rate_strobe;
      out_valid <= tick_d;
      if (tick_d) out_data <= result;
    end
  end

endmodule
